mux_scan_ctrl: RTL and testbench
================================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL, default 2, giving settle cycles per channel before sampling; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request one scan of channels 0..3; sampled in IDLE only.
REQ-005 SHALL have port cont  input  1  when 1 at end of scan, next scan starts with no IDLE cycle.
REQ-006 SHALL have port abort  input  1  stop current scan and return to IDLE.
REQ-007 SHALL have port A  output  1  select LSB to the downstream dual 4:1 mux.
REQ-008 SHALL have port B  output  1  select MSB to the downstream dual 4:1 mux.
REQ-009 SHALL have port G1_n  output  1  active-low enable, mux section 1.
REQ-010 SHALL have port G2_n  output  1  active-low enable, mux section 2.
REQ-011 SHALL have port Y1  input  1  mux section 1 output.
REQ-012 SHALL have port Y2  input  1  mux section 2 output.
REQ-013 SHALL have port data_out  output  8  scan result; bit 2*i = Y1 of channel i, bit 2*i+1 = Y2 of channel i.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse when data_out updates.

Function
REQ-016 SHALL implement states IDLE, SETTLE, SAMPLE, DONE.
REQ-017 IDLE: start=1 at an edge -> SETTLE, channel=0, dwell counter loaded.
REQ-018 SETTLE: stay exactly DWELL cycles, then -> SAMPLE.
REQ-019 SAMPLE: one cycle; at its closing edge capture Y1,Y2 into staging bits 2*ch, 2*ch+1; if ch<3, ch+1 and -> SETTLE; if ch=3 -> DONE.
REQ-020 DONE: one cycle; on entering DONE, data_out loads the full staged byte and done=1; exit -> SETTLE with ch=0 if cont=1, else -> IDLE.
REQ-021 {B,A} SHALL equal channel index (registered) throughout SETTLE and SAMPLE; {B,A}=00 in IDLE and DONE.
REQ-022 G1_n and G2_n SHALL be 0 in SETTLE and SAMPLE, 1 in IDLE and DONE.
REQ-023 Latency: with start accepted at edge 0, done is high from edge 4*(DWELL+1) to edge 4*(DWELL+1)+1.
REQ-024 start while busy SHALL be ignored; no queuing.
REQ-025 abort=1 in SETTLE or SAMPLE SHALL go to IDLE at the next edge; data_out unchanged; no done pulse; staging discarded.
REQ-026 abort and start both 1 in IDLE: abort wins, remain IDLE.
REQ-027 abort=1 in DONE: done pulse and data_out update still occur; next state IDLE regardless of cont.
REQ-028 Y1/Y2 SHALL be sampled only in SAMPLE; values in other states have no effect.
REQ-029 Channel counter SHALL be 2 bits and never wrap within a scan (3 -> DONE, not 0).

Reset
REQ-030 rst=1 SHALL immediately force IDLE, channel=0, A=B=0, G1_n=G2_n=1, data_out=8'h00, busy=0, done=0, staging=0, independent of clk.
REQ-031 rst asserted mid-scan SHALL abandon the scan with no done pulse; first start after release begins at channel 0.

Verification
REQ-032 DWELL=2, Y model returns channel-dependent values (Y1=ch[0], Y2=ch[1]); pulse start -> done high after edge 12, data_out=8'hE4, busy high edges 0..13.
REQ-033 {B,A} trace check: DWELL=2 scan -> {B,A}=00,01,10,11 each held 3 cycles; G1_n=G2_n=0 for exactly 12 cycles.
REQ-034 cont=1 held, DWELL=1 -> done pulses every 9 cycles, busy never drops, second data_out equals first for static Y.
REQ-035 abort asserted in ch2 SETTLE after a prior result 8'hE4 -> IDLE next edge, no done, data_out stays 8'hE4.
REQ-036 rst asserted asynchronously mid-SAMPLE of ch1 -> outputs at reset values before next clk edge; start after release -> full scan, done at edge 4*(DWELL+1).
REQ-037 start pulsed while busy and start+abort together in IDLE -> neither starts a scan; exactly one done per accepted start.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a dual 4:1 mux: walks channels 0..3, lets each settle
// for DWELL cycles, samples both mux outputs and publishes a packed byte.
module mux_scan_ctrl #(
    parameter int unsigned DWELL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       abort,
    output logic       A,
    output logic       B,
    output logic       G1_n,
    output logic       G2_n,
    input  logic       Y1,
    input  logic       Y2,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

    state_t     state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] stage_q, stage_d;
    logic [7:0] data_q, data_d;
    logic       scan;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= 2'd0;
            cnt_q   <= 8'd0;
            stage_q <= 8'd0;
            data_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = SETTLE;
                    ch_d    = 2'd0;
                    cnt_d   = DWELL_M1;
                    stage_d = 8'd0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    ch_d    = 2'd0;
                    stage_d = 8'd0;
                end else if (cnt_q == 8'd0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                    ch_d    = 2'd0;
                    stage_d = 8'd0;
                end else begin
                    stage_d[{ch_q, 1'b0}] = Y1;
                    stage_d[{ch_q, 1'b1}] = Y2;
                    // Last channel goes straight to the output byte.
                    if (ch_q == 2'd3) begin
                        state_d = DONE;
                        ch_d    = 2'd0;
                        data_d  = {Y2, Y1, stage_q[5:0]};
                    end else begin
                        state_d = SETTLE;
                        ch_d    = ch_q + 2'd1;
                        cnt_d   = DWELL_M1;
                    end
                end
            end
            DONE: begin
                stage_d = 8'd0;
                ch_d    = 2'd0;
                if (cont && !abort) begin
                    state_d = SETTLE;
                    cnt_d   = DWELL_M1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign scan     = (state_q == SETTLE) || (state_q == SAMPLE);
    assign A        = scan & ch_q[0];
    assign B        = scan & ch_q[1];
    assign G1_n     = ~scan;
    assign G2_n     = ~scan;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign data_out = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (DWELL=2 and DWELL=1) run against
// a scan-timer model; directed scenarios followed by random traffic.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       abort = 1'b0;
    logic       ymode = 1'b0;
    logic [1:0] ry1 = 2'b00;
    logic [1:0] ry2 = 2'b00;
    logic [1:0] y1, y2;
    logic       a [2];
    logic       b [2];
    logic       g1 [2];
    logic       g2 [2];
    logic       bsy [2];
    logic       dn [2];
    logic [7:0] dout [2];

    int tests = 0;
    int fails = 0;

    int         t [2];
    logic [7:0] stg [2];
    logic [7:0] dat [2];
    int         dw [2];

    always #5 clk = ~clk;

    // channel-dependent Y in directed mode: Y1=ch[0], Y2=ch[1]
    assign y1[0] = ymode ? a[0] : ry1[0];
    assign y2[0] = ymode ? b[0] : ry2[0];
    assign y1[1] = ymode ? a[1] : ry1[1];
    assign y2[1] = ymode ? b[1] : ry2[1];

    mux_scan_ctrl #(.DWELL(2)) u0 (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
        .A(a[0]), .B(b[0]), .G1_n(g1[0]), .G2_n(g2[0]),
        .Y1(y1[0]), .Y2(y2[0]), .data_out(dout[0]),
        .busy(bsy[0]), .done(dn[0])
    );

    mux_scan_ctrl #(.DWELL(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
        .A(a[1]), .B(b[1]), .G1_n(g1[1]), .G2_n(g2[1]),
        .Y1(y1[1]), .Y2(y2[1]), .data_out(dout[1]),
        .busy(bsy[1]), .done(dn[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void mreset();
        for (int i = 0; i < 2; i++) begin
            t[i]   = -1;
            stg[i] = 8'h00;
            dat[i] = 8'h00;
        end
    endfunction

    // t = cycles since scan start; -1 idle, n = 4*(DWELL+1) is the DONE cycle
    function automatic void mstep(input int i);
        int n;
        int ch;
        logic [1:0] cb;
        n = 4 * (dw[i] + 1);
        if (t[i] < 0) begin
            if (start && !abort) begin
                t[i] = 0;
                stg[i] = 8'h00;
            end
        end else if (t[i] == n) begin
            if (cont && !abort) begin
                t[i] = 0;
                stg[i] = 8'h00;
            end else begin
                t[i] = -1;
            end
        end else if (abort) begin
            t[i] = -1;
        end else begin
            ch = t[i] / (dw[i] + 1);
            cb = ch[1:0];
            if (t[i] % (dw[i] + 1) == dw[i]) begin
                stg[i][2*ch]   = ymode ? cb[0] : ry1[i];
                stg[i][2*ch+1] = ymode ? cb[1] : ry2[i];
                if (ch == 3) dat[i] = stg[i];
            end
            t[i]++;
        end
    endfunction

    function automatic logic [13:0] mexp(input int i);
        int n;
        int ch;
        logic [1:0] cb;
        n = 4 * (dw[i] + 1);
        if (t[i] < 0)
            return {2'b00, 2'b00, 2'b11, dat[i]};
        if (t[i] == n)
            return {2'b11, 2'b00, 2'b11, dat[i]};
        ch = t[i] / (dw[i] + 1);
        cb = ch[1:0];
        return {2'b10, cb, 2'b00, dat[i]};
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++)
            chk($sformatf("%s_u%0d", tag, i),
                {18'd0, bsy[i], dn[i], b[i], a[i], g1[i], g2[i], dout[i]},
                {18'd0, mexp(i)});
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        mstep(0);
        mstep(1);
        #1;
        check_all(tag);
    endtask

    int k, glow, gap, ndone;

    initial begin
        dw[0] = 2;
        dw[1] = 1;
        mreset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
        cyc("idle");

        // single scan, latency and select trace
        ymode = 1'b1;
        start = 1'b1;
        cyc("scan_start");
        start = 1'b0;
        k = 0;
        glow = (g1[0] == 1'b0) ? 1 : 0;
        while (!dn[0] && k < 40) begin
            cyc("scan");
            k++;
            if (!g1[0]) glow++;
        end
        chk("latency_d2", k, 12);
        chk("glow_d2", glow, 12);
        chk("data_e4", {24'd0, dout[0]}, 32'hE4);
        cyc("scan_tail");
        chk("busy_end", {31'd0, bsy[0]}, 0);
        repeat (4) cyc("idle2");

        // continuous mode on DWELL=1 instance
        cont = 1'b1;
        start = 1'b1;
        cyc("cont_start");
        start = 1'b0;
        k = 0;
        while (!dn[1] && k < 40) begin cyc("cont"); k++; end
        gap = 0;
        cyc("cont");
        gap = 1;
        while (!dn[1] && gap < 40) begin
            chk("cont_busy", {31'd0, bsy[1]}, 1);
            cyc("cont");
            gap++;
        end
        chk("cont_period", gap, 9);
        chk("cont_data", {24'd0, dout[1]}, 32'hE4);
        cont = 1'b0;
        abort = 1'b1;
        cyc("cont_abort");
        abort = 1'b0;
        repeat (16) cyc("settle_out");

        // abort in channel 2 settle
        start = 1'b1;
        cyc("ab_start");
        start = 1'b0;
        k = 0;
        while (t[0] != 6 && k < 40) begin cyc("ab_run"); k++; end
        abort = 1'b1;
        cyc("ab_hit");
        abort = 1'b0;
        chk("ab_busy", {31'd0, bsy[0]}, 0);
        chk("ab_data", {24'd0, dout[0]}, 32'hE4);
        ndone = 0;
        repeat (20) begin cyc("ab_after"); if (dn[0]) ndone++; end
        chk("ab_nodone", ndone, 0);

        // start while busy and start+abort in idle
        start = 1'b1;
        abort = 1'b1;
        cyc("sa_idle");
        chk("sa_busy", {31'd0, bsy[0]}, 0);
        abort = 1'b0;
        cyc("one_start");
        ndone = 0;
        for (int j = 0; j < 30; j++) begin
            start = (j % 3 == 0) && (j < 9);
            cyc("busy_start");
            if (dn[0]) ndone++;
        end
        start = 1'b0;
        chk("one_done", ndone, 1);

        // async reset in channel 1 sample
        start = 1'b1;
        cyc("rs_start");
        start = 1'b0;
        k = 0;
        while (t[0] != 5 && k < 40) begin cyc("rs_run"); k++; end
        #2;
        rst = 1'b1;
        mreset();
        #1;
        check_all("async_rst");
        #1;
        rst = 1'b0;
        cyc("rs_idle");
        start = 1'b1;
        cyc("rs_restart");
        start = 1'b0;
        k = 0;
        while (!dn[0] && k < 40) begin cyc("rs_scan"); k++; end
        chk("rs_latency", k, 12);
        repeat (4) cyc("rs_tail");

        // random traffic
        ymode = 1'b0;
        for (int j = 0; j < 800; j++) begin
            start = ($urandom_range(3) == 0);
            cont  = ($urandom_range(1) == 0);
            abort = ($urandom_range(24) == 0);
            ry1   = 2'($urandom);
            ry2   = 2'($urandom);
            cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
